// File: rtl/lsu_pkg.sv
// Shared definitions for the byte-serial load/store unit.
package lsu_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_XFER = 2'd1,
    S_RESP = 2'd2
  } lsu_state_e;

  // Access size in bytes: 1, 2, 4 or 8.
  function automatic logic [3:0] size_bytes(input logic [1:0] sz);
    return 4'd1 << sz;
  endfunction

  // Sign- or zero-extend the low 8N bits of d to 64 bits.
  function automatic logic [63:0] lsu_extend(input logic [63:0] d,
                                             input logic [1:0]  sz,
                                             input logic        uns);
    logic [63:0] r;
    r = d;
    case (sz)
      SZ_B:    r = {{56{~uns & d[7]}},  d[7:0]};
      SZ_H:    r = {{48{~uns & d[15]}}, d[15:0]};
      SZ_W:    r = {{32{~uns & d[31]}}, d[31:0]};
      default: r = d;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/load_store_unit.sv
// Load/store unit: moves 1..8 bytes one per cycle over a byte-wide memory port.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W    = 64,
  parameter int MEM_BYTES = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [63:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [63:0]       rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata
);

  localparam int AW1 = ADDR_W + 1;

  lsu_state_e        state_q, state_d;
  logic [2:0]        k_q, k_d;
  logic              write_q;
  logic [1:0]        size_q;
  logic              uns_q;
  logic [ADDR_W-1:0] addr_q;
  logic [63:0]       wdata_q;
  logic [63:0]       data_q;
  logic              err_q;

  logic              accept;
  logic [3:0]        req_n;
  logic [3:0]        req_nm1;
  logic [3:0]        cur_nm1;
  logic              misalign;
  logic [AW1-1:0]    end_addr;
  logic              oob;
  logic              req_err;
  logic              last_byte;

  // Error check on the incoming request; the end address is one bit wider
  // than the address so a request near the top of the space cannot wrap.
  always_comb begin
    req_n    = size_bytes(req_size);
    req_nm1  = req_n - 4'd1;
    misalign = (req_addr[2:0] & req_nm1[2:0]) != 3'd0;
    end_addr = {1'b0, req_addr} + AW1'(req_n);
    oob      = end_addr > AW1'(MEM_BYTES);
    req_err  = misalign | oob;
    accept   = req_valid & (state_q == S_IDLE);
    cur_nm1  = size_bytes(size_q) - 4'd1;
    last_byte = (k_q == cur_nm1[2:0]);
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    case (state_q)
      S_IDLE: begin
        k_d = 3'd0;
        if (req_valid) state_d = req_err ? S_RESP : S_XFER;
      end
      S_XFER: begin
        if (last_byte) state_d = S_RESP;
        else           k_d     = k_q + 3'd1;
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decode straight from registered state so reset clears them at once.
  always_comb begin
    req_ready = (state_q == S_IDLE);
    rsp_valid = (state_q == S_RESP);
    rsp_err   = (state_q == S_RESP) & err_q;
    rsp_rdata = '0;
    if ((state_q == S_RESP) && !err_q && !write_q)
      rsp_rdata = lsu_extend(data_q, size_q, uns_q);
    mem_addr  = '0;
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    mem_wdata = 8'h00;
    if (state_q == S_XFER) begin
      mem_addr  = addr_q + ADDR_W'(k_q);
      mem_re    = ~write_q;
      mem_we    = write_q;
      mem_wdata = wdata_q[{k_q, 3'b000} +: 8];
    end
  end

  // FSM state and byte index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      k_q     <= 3'd0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
    end
  end

  // Request latch and load-data assembly, one byte per XFER cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      write_q <= 1'b0;
      size_q  <= SZ_B;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else if (accept) begin
      write_q <= req_write;
      size_q  <= req_size;
      uns_q   <= req_unsigned;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
      data_q  <= '0;
      err_q   <= req_err;
    end else if ((state_q == S_XFER) && !write_q) begin
      data_q[{k_q, 3'b000} +: 8] <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized scoreboard bench for load_store_unit with a byte-array memory model.
module tb_load_store_unit;

  localparam int MB = 64;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_write, req_unsigned;
  logic [1:0]  req_size;
  logic [63:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [63:0] rsp_rdata;
  logic [63:0] mem_addr;
  logic        mem_re, mem_we;
  logic [7:0]  mem_wdata, mem_rdata;

  load_store_unit #(.ADDR_W(64), .MEM_BYTES(MB)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err),
    .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Attached memory device, loaded from the initial image on the first edge.
  logic [7:0] mem [MB];
  logic [7:0] init_img [MB];
  bit         mem_loaded = 1'b0;
  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < MB; i++) mem[i] <= init_img[i];
      mem_loaded <= 1'b1;
    end else if (mem_we && mem_addr < MB) begin
      mem[mem_addr[5:0]] <= mem_wdata;
    end
  end
  assign mem_rdata = (mem_addr < MB) ? mem[mem_addr[5:0]] : 8'h00;

  // Reference model state and scoreboard.
  logic [7:0] ref_mem [MB];
  typedef struct {
    logic [63:0] rdata;
    bit          err;
    int          nstrobe;
    int          lat;
    int          acc;
    int          hold;
  } exp_t;
  exp_t q[$];

  bit          active = 1'b0;
  logic [63:0] cur_base, cur_wdata;
  bit          cur_write;
  int          strobe_cnt = 0;
  int          done_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  function automatic bit model_err(input logic [63:0] a, input int n);
    longint unsigned lim;
    lim = longint'(MB - n);
    return ((a % n) != 0) || (a > lim);
  endfunction

  function automatic logic [63:0] model_load(input logic [63:0] a, input int n, input bit uns);
    logic [63:0] v;
    v = 64'd0;
    for (int i = 0; i < n; i++) v = v | (64'(ref_mem[int'(a) + i]) << (8 * i));
    if (!uns && n < 8 && v[8 * n - 1]) v = v | (~64'd0 << (8 * n));
    return v;
  endfunction

  // Strobe monitor: every strobe must belong to the current access and walk its bytes.
  always @(negedge clk) begin
    if (mem_we || mem_re) begin
      if (!active) begin
        chk("stray_strobe", {62'd0, mem_we, mem_re}, 64'd0);
      end else begin
        chk("strobe_addr", mem_addr, cur_base + 64'(strobe_cnt));
        chk("strobe_dir", {62'd0, mem_we, mem_re}, {62'd0, cur_write, !cur_write});
        if (cur_write) chk("strobe_wdata", 64'(mem_wdata), 64'(cur_wdata[8 * strobe_cnt +: 8]));
        strobe_cnt++;
      end
    end
  end

  // Response monitor: latency, stability under backpressure, then compare and pop.
  int          hold_cnt = 0;
  bit          have_prev = 1'b0;
  logic [63:0] prev_rdata;
  logic        prev_err;
  always @(negedge clk) begin
    if (!rst_n) begin
      rsp_ready = 1'b0;
      hold_cnt  = 0;
      have_prev = 1'b0;
      if (rsp_valid) chk("rsp_in_reset", 64'(rsp_valid), 64'd0);
    end else if (rsp_valid) begin
      if (q.size() == 0) begin
        chk("spurious_rsp", 64'(rsp_valid), 64'd0);
      end else begin
        exp_t e;
        e = q[0];
        if (!have_prev) begin
          chk("rsp_latency", 64'(cyc - e.acc), 64'(e.lat));
          prev_rdata = rsp_rdata;
          prev_err   = rsp_err;
          have_prev  = 1'b1;
        end else begin
          chk("rsp_rdata_stable", rsp_rdata, prev_rdata);
          chk("rsp_err_stable", 64'(rsp_err), 64'(prev_err));
        end
        chk("req_ready_in_resp", 64'(req_ready), 64'd0);
        if (hold_cnt < e.hold) begin
          hold_cnt++;
          rsp_ready = 1'b0;
        end else begin
          chk("rsp_rdata", rsp_rdata, e.rdata);
          chk("rsp_err", 64'(rsp_err), 64'(e.err));
          chk("strobe_count", 64'(strobe_cnt), 64'(e.nstrobe));
          rsp_ready = 1'b1;
          void'(q.pop_front());
          hold_cnt  = 0;
          have_prev = 1'b0;
          active    = 1'b0;
          done_cnt++;
        end
      end
    end else begin
      rsp_ready = 1'b0;
    end
  end

  task automatic finish_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  endtask

  // Present one access and push its expected response; does not wait for it.
  task automatic issue(input bit w, input logic [1:0] sz, input bit uns,
                       input logic [63:0] a, input logic [63:0] wd, input int hold);
    exp_t e;
    int   n;
    bit   ok;
    n  = 1 << sz;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (req_ready) begin ok = 1'b1; break; end
    end
    chk("req_ready_wait", 64'(ok), 64'd1);
    e.err     = model_err(a, n);
    e.rdata   = (e.err || w) ? 64'd0 : model_load(a, n, uns);
    e.nstrobe = e.err ? 0 : n;
    e.lat     = e.err ? 0 : n;
    e.hold    = hold;
    if (!e.err && w)
      for (int i = 0; i < n; i++) ref_mem[int'(a) + i] = wd[8 * i +: 8];
    cur_base     = a;
    cur_write    = w;
    cur_wdata    = wd;
    strobe_cnt   = 0;
    active       = 1'b1;
    req_write    = w;
    req_size     = sz;
    req_unsigned = uns;
    req_addr     = a;
    req_wdata    = wd;
    req_valid    = 1'b1;
    @(posedge clk);
    #1;
    e.acc = cyc;
    q.push_back(e);
    req_valid = 1'b0;
  endtask

  task automatic wait_done();
    int  d0;
    bit  ok;
    d0 = done_cnt;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      #1;
      if (done_cnt != d0) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      chk("rsp_timeout", 64'(ok), 64'd1);
      finish_run();
    end
  endtask

  task automatic access(input bit w, input logic [1:0] sz, input bit uns,
                        input logic [63:0] a, input logic [63:0] wd, input int hold);
    issue(w, sz, uns, a, wd, hold);
    wait_done();
  endtask

  initial begin
    logic [7:0]  old [8];
    logic [63:0] d;
    bit          hit;

    for (int i = 0; i < MB; i++) begin
      init_img[i] = 8'($urandom);
      ref_mem[i]  = init_img[i];
    end
    init_img[0] = 8'hFF;
    ref_mem[0]  = 8'hFF;

    rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0;
    req_unsigned = 1'b0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_err", 64'(rsp_err), 64'd0);
    chk("rst_rsp_rdata", rsp_rdata, 64'd0);
    chk("rst_strobes", {62'd0, mem_we, mem_re}, 64'd0);
    chk("rst_mem_addr", mem_addr, 64'd0);
    chk("rst_mem_wdata", 64'(mem_wdata), 64'd0);
    rst_n = 1'b1;

    // Byte loads of 0xFF, signed and unsigned.
    access(1'b0, 2'd0, 1'b0, 64'd0, 64'd0, 0);
    access(1'b0, 2'd0, 1'b1, 64'd0, 64'd0, 0);
    // Double store then load back.
    access(1'b1, 2'd3, 1'b0, 64'd8, 64'h0123_4567_89AB_CDEF, 1);
    access(1'b0, 2'd3, 1'b0, 64'd8, 64'd0, 0);
    // Misaligned half, out-of-range and top-of-range doubles, wrap-around address.
    access(1'b0, 2'd1, 1'b0, 64'd3, 64'd0, 0);
    access(1'b0, 2'd3, 1'b0, 64'd60, 64'd0, 0);
    access(1'b0, 2'd3, 1'b0, 64'd56, 64'd0, 0);
    access(1'b0, 2'd3, 1'b0, 64'hFFFF_FFFF_FFFF_FFF8, 64'd0, 0);
    access(1'b1, 2'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h5A, 0);
    // Backpressure: response held for five cycles.
    access(1'b0, 2'd2, 1'b0, 64'd8, 64'd0, 5);

    // Random mix of sizes, directions and addresses, some near the top of space.
    for (int t = 0; t < 80; t++) begin
      logic [63:0] a;
      logic [1:0]  sz;
      sz = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) a = 64'hFFFF_FFFF_FFFF_FFC0 + 64'($urandom_range(0, 63));
      else if ($urandom_range(0, 2) == 0) a = 64'($urandom_range(0, 71));
      else a = 64'($urandom_range(0, 8)) << sz;
      access(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a,
             {$urandom, $urandom}, $urandom_range(0, 3));
    end

    // Reset in the middle of a double store, after the fourth strobe starts.
    for (int i = 0; i < 8; i++) old[i] = ref_mem[i];
    d = 64'hA1B2_C3D4_E5F6_0718;
    issue(1'b1, 2'd3, 1'b0, 64'd0, d, 0);
    hit = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      #1;
      if (strobe_cnt >= 4) begin hit = 1'b1; break; end
    end
    chk("reached_k3", 64'(hit), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_strobes", {62'd0, mem_we, mem_re}, 64'd0);
    chk("mid_rst_req_ready", 64'(req_ready), 64'd1);
    chk("mid_rst_rsp_valid", 64'(rsp_valid), 64'd0);
    q.delete();
    active = 1'b0;
    for (int i = 3; i < 8; i++) ref_mem[i] = old[i];
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    for (int i = 0; i < 8; i++) chk("mem_after_rst", 64'(mem[i]), 64'(ref_mem[i]));
    chk("byte0_written", 64'(mem[0]), 64'(d[7:0]));
    chk("byte3_kept", 64'(mem[3]), 64'(old[3]));
    access(1'b0, 2'd3, 1'b0, 64'd0, 64'd0, 2);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 64'(q.size()), 64'd0);
    finish_run();
  end

endmodule
